ex_mdu_seq: RTL and testbench

EX_MDU_SEQ -- requirements
Module: ex_mdu_seq

---
 rtl/ex_mdu_seq.sv | 172 +++++++++++++++++
 tb/tb_ex_mdu_seq.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mdu_seq.sv
// Sequential RV32M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide, one bit per cycle, on operand
// magnitudes. Sign correction is applied when the final result is formed.
module ex_mdu_seq (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_vld,
   input  logic        i_mdu,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_op1,
   input  logic [31:0] i_op2,
   input  logic [4:0]  i_rd_waddr,
   input  logic        i_flush,
   output logic        o_stall,
   output logic        o_busy,
   output logic        o_vld,
   output logic [31:0] o_res,
   output logic [4:0]  o_rd_waddr,
   output logic        o_rd_wen
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned CW   = 5;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t              state;
   logic [CW-1:0]       cnt;
   logic [2*XLEN-1:0]   acc;     // MUL: product; DIV: {remainder, quotient}
   logic [XLEN-1:0]     opb;     // multiplicand / divisor magnitude
   logic [2:0]          f3;
   logic                neg_q;   // product or quotient sign
   logic                neg_r;   // remainder sign

   logic                accept;
   logic                s1, s2;
   logic [XLEN-1:0]     mag1, mag2;
   logic                special;
   logic [XLEN-1:0]     special_res;

   logic [XLEN:0]       mul_sum;
   logic [2*XLEN-1:0]   mul_nx;
   logic [2*XLEN-1:0]   mul_p;
   logic [XLEN-1:0]     mul_res;
   logic [XLEN:0]       rem_sh;
   logic [XLEN:0]       div_diff;
   logic [2*XLEN-1:0]   div_nx;
   logic [XLEN-1:0]     div_quo;
   logic [XLEN-1:0]     div_rem;
   logic [XLEN-1:0]     div_res;

   assign accept = (state == S_IDLE) & i_vld & i_mdu & ~i_flush;

   // Operand sign decode, magnitudes and divide special cases at accept.
   always_comb begin
      logic op1_signed;
      logic op2_signed;
      logic div_zero;
      logic div_ovf;
      op1_signed  = 1'b0;
      op2_signed  = 1'b0;
      div_zero    = 1'b0;
      div_ovf     = 1'b0;
      s1          = 1'b0;
      s2          = 1'b0;
      mag1        = i_op1;
      mag2        = i_op2;
      special     = 1'b0;
      special_res = '0;
      if (i_funct3[2]) begin
         op1_signed = ~i_funct3[0];
         op2_signed = ~i_funct3[0];
      end else begin
         op1_signed = (i_funct3[1:0] == 2'b01) | (i_funct3[1:0] == 2'b10);
         op2_signed = (i_funct3[1:0] == 2'b01);
      end
      s1   = op1_signed & i_op1[XLEN-1];
      s2   = op2_signed & i_op2[XLEN-1];
      mag1 = s1 ? XLEN'(-i_op1) : i_op1;
      mag2 = s2 ? XLEN'(-i_op2) : i_op2;
      div_zero = i_funct3[2] & (i_op2 == '0);
      div_ovf  = i_funct3[2] & ~i_funct3[0] &
                 (i_op1 == 32'h8000_0000) & (i_op2 == 32'hFFFF_FFFF);
      special  = div_zero | div_ovf;
      if (div_zero)
         special_res = i_funct3[1] ? i_op1 : 32'hFFFF_FFFF;
      else
         special_res = i_funct3[1] ? 32'h0000_0000 : 32'h8000_0000;
   end

   // One iteration of multiply and divide plus final sign-corrected result.
   always_comb begin
      mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
      mul_nx   = {mul_sum, acc[XLEN-1:1]};
      mul_p    = neg_q ? (2*XLEN)'(-mul_nx) : mul_nx;
      mul_res  = (f3[1:0] == 2'b00) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
      rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      div_diff = rem_sh - {1'b0, opb};
      if (div_diff[XLEN])
         div_nx = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else
         div_nx = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      div_quo  = div_nx[XLEN-1:0];
      div_rem  = div_nx[2*XLEN-1:XLEN];
      if (f3[1])
         div_res = neg_r ? XLEN'(-div_rem) : div_rem;
      else
         div_res = neg_q ? XLEN'(-div_quo) : div_quo;
   end

   // Control FSM and datapath registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         acc        <= '0;
         opb        <= '0;
         f3         <= '0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         o_res      <= '0;
         o_rd_waddr <= '0;
      end else if (i_flush) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  f3         <= i_funct3;
                  o_rd_waddr <= i_rd_waddr;
                  neg_q      <= s1 ^ s2;
                  neg_r      <= s1;
                  opb        <= mag2;
                  acc        <= {{XLEN{1'b0}}, mag1};
                  cnt        <= '0;
                  if (special) begin
                     o_res <= special_res;
                     state <= S_DONE;
                  end else begin
                     state <= i_funct3[2] ? S_DIV : S_MUL;
                  end
               end
            end
            S_MUL: begin
               acc <= mul_nx;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(XLEN - 1)) begin
                  o_res <= mul_res;
                  state <= S_DONE;
               end
            end
            S_DIV: begin
               acc <= div_nx;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(XLEN - 1)) begin
                  o_res <= div_res;
                  state <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Handshake outputs; flush suppresses the result pulse.
   assign o_busy   = (state != S_IDLE);
   assign o_stall  = accept | (state == S_MUL) | (state == S_DIV);
   assign o_vld    = (state == S_DONE) & ~i_flush;
   assign o_rd_wen = o_vld;

endmodule

// File: tb/tb_ex_mdu_seq.sv
// Self-checking bench for ex_mdu_seq: directed table, random ops against an
// arithmetic reference model, and flush/reset/back-to-back sequences.
module tb_ex_mdu_seq;

   logic        clk;
   logic        rst;
   logic        vld;
   logic        mdu;
   logic [2:0]  funct3;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [4:0]  rd;
   logic        flush;
   logic        stall;
   logic        busy;
   logic        ovld;
   logic [31:0] res;
   logic [4:0]  rd_waddr;
   logic        rd_wen;

   int n_chk  = 0;
   int n_fail = 0;

   ex_mdu_seq dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_vld      (vld),
      .i_mdu      (mdu),
      .i_funct3   (funct3),
      .i_op1      (op1),
      .i_op2      (op2),
      .i_rd_waddr (rd),
      .i_flush    (flush),
      .o_stall    (stall),
      .o_busy     (busy),
      .o_vld      (ovld),
      .o_res      (res),
      .o_rd_waddr (rd_waddr),
      .o_rd_wen   (rd_wen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      vld = 1'b0; mdu = 1'b0; flush = 1'b0; rst = 1'b0;
      funct3 = '0; op1 = '0; op2 = '0; rd = '0;
   endtask

   // Architectural RV32M result computed with plain 64-bit arithmetic.
   function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      int          ia, ib;
      logic        ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = longint'({32'd0, a});
      ub  = longint'({32'd0, b});
      ia  = $signed(a);
      ib  = $signed(b);
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = '0;
      case (f3)
         3'd0: begin p = 64'(ua * ub); return p[31:0];  end
         3'd1: begin p = 64'(sa * sb); return p[63:32]; end
         3'd2: begin p = 64'(sa * ub); return p[63:32]; end
         3'd3: begin p = 64'(ua * ub); return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf)    return 32'h8000_0000;
            return 32'(ia / ib);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf)    return 32'h0;
            return 32'(ia % ib);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b);
      if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
         return 1;
      return 33;
   endfunction

   // Issue one op in the current cycle and check its completion.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input logic [31:0] exp, input int lat,
                         input string tag);
      int          cyc;
      int          vcyc;
      logic        got;
      logic        stall_bad;
      logic [31:0] r;
      logic [4:0]  w;
      logic        wen;
      logic        st_done;
      vld = 1'b1; mdu = 1'b1; funct3 = f3; op1 = a; op2 = b; rd = d;
      @(negedge clk);
      check({tag, " stall@0"}, 32'(stall), 32'd1);
      tick();
      vld = 1'b0; mdu = 1'b0;
      cyc = 1; got = 1'b0; stall_bad = 1'b0; vcyc = 0;
      r = '0; w = '0; wen = 1'b0; st_done = 1'b0;
      while (cyc <= 40 && !got) begin
         @(negedge clk);
         if (ovld) begin
            got = 1'b1; vcyc = cyc; r = res; w = rd_waddr; wen = rd_wen; st_done = stall;
         end else if (!stall) begin
            stall_bad = 1'b1;
         end
         tick();
         cyc++;
      end
      check({tag, " vld seen"}, 32'(got), 32'd1);
      if (got) begin
         check({tag, " latency"}, 32'(vcyc), 32'(lat));
         check({tag, " res"}, r, exp);
         check({tag, " rd"}, 32'(w), 32'(d));
         check({tag, " wen"}, 32'(wen), 32'd1);
         check({tag, " stall in done"}, 32'(st_done), 32'd0);
         check({tag, " stall gap"}, 32'(stall_bad), 32'd0);
      end
      @(negedge clk);
      check({tag, " vld pulse"}, 32'(ovld), 32'd0);
      check({tag, " idle after"}, 32'(busy), 32'd0);
      tick();
   endtask

   function automatic logic [31:0] rand_opnd();
      logic [31:0] edges[5];
      edges[0] = 32'h0; edges[1] = 32'h1; edges[2] = 32'hFFFF_FFFF;
      edges[3] = 32'h8000_0000; edges[4] = 32'h7FFF_FFFF;
      case ($urandom_range(0, 3))
         0: return $urandom;
         1: return 32'($urandom_range(0, 20));
         2: return 32'(-$urandom_range(0, 20));
         default: return edges[$urandom_range(0, 4)];
      endcase
   endfunction

   initial begin
      int          vcount;
      int          vc[$];
      logic [31:0] vr[$];
      logic [2:0]  f;
      logic [31:0] a, b;

      vecs[0]  = '{f3:3'd0, a:32'd7,          b:32'hFFFF_FFFD, rd:5'd5,  exp:32'hFFFF_FFEB, lat:33};
      vecs[1]  = '{f3:3'd3, a:32'hFFFF_FFFF,  b:32'hFFFF_FFFF, rd:5'd1,  exp:32'hFFFF_FFFE, lat:33};
      vecs[2]  = '{f3:3'd1, a:32'hFFFF_FFFF,  b:32'hFFFF_FFFF, rd:5'd2,  exp:32'h0000_0000, lat:33};
      vecs[3]  = '{f3:3'd4, a:32'hFFFF_FFF9,  b:32'd2,         rd:5'd3,  exp:32'hFFFF_FFFD, lat:33};
      vecs[4]  = '{f3:3'd6, a:32'hFFFF_FFF9,  b:32'd2,         rd:5'd4,  exp:32'hFFFF_FFFF, lat:33};
      vecs[5]  = '{f3:3'd5, a:32'd100,        b:32'd7,         rd:5'd6,  exp:32'd14,        lat:33};
      vecs[6]  = '{f3:3'd7, a:32'd100,        b:32'd7,         rd:5'd7,  exp:32'd2,         lat:33};
      vecs[7]  = '{f3:3'd5, a:32'h1234,       b:32'd0,         rd:5'd8,  exp:32'hFFFF_FFFF, lat:1};
      vecs[8]  = '{f3:3'd7, a:32'h1234,       b:32'd0,         rd:5'd9,  exp:32'h0000_1234, lat:1};
      vecs[9]  = '{f3:3'd4, a:32'h8000_0000,  b:32'hFFFF_FFFF, rd:5'd10, exp:32'h8000_0000, lat:1};
      vecs[10] = '{f3:3'd6, a:32'h8000_0000,  b:32'hFFFF_FFFF, rd:5'd11, exp:32'h0000_0000, lat:1};
      vecs[11] = '{f3:3'd4, a:32'hFFFF_FFF9,  b:32'd0,         rd:5'd12, exp:32'hFFFF_FFFF, lat:1};
      vecs[12] = '{f3:3'd6, a:32'hFFFF_FFF9,  b:32'd0,         rd:5'd13, exp:32'hFFFF_FFF9, lat:1};
      vecs[13] = '{f3:3'd2, a:32'hFFFF_FFFF,  b:32'd2,         rd:5'd31, exp:32'hFFFF_FFFF, lat:33};

      idle_inputs();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst stall", 32'(stall), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst vld", 32'(ovld), 32'd0);
      check("rst res", res, 32'd0);
      check("rst rd", 32'(rd_waddr), 32'd0);
      check("rst wen", 32'(rd_wen), 32'd0);
      tick();

      // Non-MDU and flushed instructions in IDLE are ignored.
      vld = 1'b1; mdu = 1'b0; funct3 = 3'd0; op1 = 32'd3; op2 = 32'd4;
      @(negedge clk);
      check("nonmdu stall", 32'(stall), 32'd0);
      tick();
      mdu = 1'b1; flush = 1'b1;
      @(negedge clk);
      check("nonmdu busy", 32'(busy), 32'd0);
      check("flush-accept stall", 32'(stall), 32'd0);
      tick();
      idle_inputs();
      @(negedge clk);
      check("flush-accept busy", 32'(busy), 32'd0);
      tick();

      for (int i = 0; i < 14; i++)
         run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat,
                $sformatf("vec%0d", i));

      for (int i = 0; i < 40; i++) begin
         f = 3'($urandom_range(0, 7));
         a = rand_opnd();
         b = rand_opnd();
         run_op(f, a, b, 5'($urandom_range(0, 31)), ref_mdu(f, a, b), ref_lat(f, a, b),
                $sformatf("rnd%0d f%0d %h %h", i, f, a, b));
      end

      // Flush a MUL at cycle 10.
      vcount = 0;
      for (int c = 0; c <= 40; c++) begin
         idle_inputs();
         if (c == 0) begin
            vld = 1'b1; mdu = 1'b1; funct3 = 3'd0; op1 = 32'd5; op2 = 32'd9; rd = 5'd3;
         end
         if (c == 10) flush = 1'b1;
         @(negedge clk);
         if (ovld) vcount++;
         if (c == 11) begin
            check("flush busy", 32'(busy), 32'd0);
            check("flush stall", 32'(stall), 32'd0);
         end
         tick();
      end
      check("flush no vld", 32'(vcount), 32'd0);
      run_op(3'd0, 32'd6, 32'd7, 5'd4, 32'd42, 33, "after flush");

      // Flush during DONE suppresses the result.
      vld = 1'b1; mdu = 1'b1; funct3 = 3'd5; op1 = 32'h55; op2 = 32'd0; rd = 5'd2;
      tick();
      idle_inputs();
      flush = 1'b1;
      @(negedge clk);
      check("flush done vld", 32'(ovld), 32'd0);
      check("flush done wen", 32'(rd_wen), 32'd0);
      tick();
      idle_inputs();
      @(negedge clk);
      check("flush done idle", 32'(busy), 32'd0);
      tick();

      // Reset a DIV at cycle 20.
      vcount = 0;
      for (int c = 0; c <= 40; c++) begin
         idle_inputs();
         if (c == 0) begin
            vld = 1'b1; mdu = 1'b1; funct3 = 3'd5; op1 = 32'd100; op2 = 32'd7; rd = 5'd9;
         end
         if (c == 20) rst = 1'b1;
         @(negedge clk);
         if (c > 20 && ovld) vcount++;
         if (c == 21) begin
            check("midrst stall", 32'(stall), 32'd0);
            check("midrst busy", 32'(busy), 32'd0);
            check("midrst vld", 32'(ovld), 32'd0);
            check("midrst res", res, 32'd0);
            check("midrst rd", 32'(rd_waddr), 32'd0);
            check("midrst wen", 32'(rd_wen), 32'd0);
         end
         tick();
      end
      check("midrst no vld", 32'(vcount), 32'd0);
      run_op(3'd7, 32'd100, 32'd7, 5'd9, 32'd2, 33, "after rst");

      // Back-to-back MUL then DIV presented right after DONE.
      for (int c = 0; c <= 80; c++) begin
         idle_inputs();
         if (c == 0) begin
            vld = 1'b1; mdu = 1'b1; funct3 = 3'd0; op1 = 32'd7; op2 = 32'hFFFF_FFFD; rd = 5'd5;
         end
         if (c == 34) begin
            vld = 1'b1; mdu = 1'b1; funct3 = 3'd5; op1 = 32'd100; op2 = 32'd7; rd = 5'd6;
         end
         @(negedge clk);
         if (ovld) begin
            vc.push_back(c);
            vr.push_back(res);
         end
         tick();
      end
      check("b2b count", 32'(vc.size()), 32'd2);
      if (vc.size() == 2) begin
         check("b2b mul cycle", 32'(vc[0]), 32'd33);
         check("b2b mul res", vr[0], 32'hFFFF_FFEB);
         check("b2b div cycle", 32'(vc[1]), 32'd67);
         check("b2b div res", vr[1], 32'd14);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
